alp_dq_reg: RTL and testbench
=============================

Name: alp_dq_reg

Overview:
- Storage stage directly downstream of the ALP D/Q decoder.
- Holds one ALP slice's Q register (multiply/divide/shift scratch) and D register (data latch feeding the ALU D operand).
- Consumes the decoder's Q mux one-hot, Q/D write enables and the Q shift-enable lines, and updates both registers on the clock edge.
- Drives register contents plus MSB/LSB shift-out bits to the adjacent slices and to the ALU operand muxes.

Parameters:
- WIDTH, 8: slice data width in bits; minimum 2.

Ports:
- clk  input  1  datapath clock; all state updates on rising edge.
- reset_h  input  1  synchronous active-high reset; sampled on rising edge of clk.
- qmux_onehot_h  input  4  Q source select from decoder: bit3 W mux, bit2 shift left, bit1 shift right, bit0 A mux.
- qreg_en_h  input  1  Q register write enable.
- dreg_en_h  input  1  D register write enable (already includes ALPCTL inhibit).
- dshift_h  input  2  D operation: 00 load W, 01 shift right, 10 shift left, 11 hold.
- amux_h  input  WIDTH  A mux data (Q load source when DMOVE).
- wmux_h  input  WIDTH  W mux data (Q and D load source).
- qshl_in_h  input  1  bit shifted into Q[0] on Q shift left (from lower slice).
- qshr_in_h  input  1  bit shifted into Q[WIDTH-1] on Q shift right (from upper slice).
- dshl_in_h  input  1  bit shifted into D[0] on D shift left.
- dshr_in_h  input  1  bit shifted into D[WIDTH-1] on D shift right.
- q_h  output  WIDTH  Q register contents.
- d_h  output  WIDTH  D register contents.
- qmsb_h  output  1  Q[WIDTH-1], shift-out to upper slice.
- qlsb_h  output  1  Q[0], shift-out to lower slice.
- dmsb_h  output  1  D[WIDTH-1].
- dlsb_h  output  1  D[0].

Behaviour:
- Reset: Q=0, D=0; therefore q_h=0, d_h=0 and all shift-out bits 0. Reset wins over every enable in the same cycle. A reset asserted mid-shift-sequence discards partial results; the first edge after reset deasserts may load normally.
- Outputs: q_h, d_h, msb/lsb bits are pure register outputs; no combinational path from any input. The new value is visible the cycle after the enabling edge; latency is 1.
- Q update on edge when qreg_en_h=1:
  - Select source from qmux_onehot_h with fixed priority bit3 > bit2 > bit1 > bit0. This resolves the decoder's legal shl+shr overlap deterministically.
  - W mux: Q <= wmux_h.
  - Shift left: Q <= {Q[WIDTH-2:0], qshl_in_h}.
  - Shift right: Q <= {qshr_in_h, Q[WIDTH-1:1]}.
  - A mux: Q <= amux_h.
  - qmux_onehot_h = 0000: Q holds.
- qreg_en_h=0: Q holds regardless of qmux_onehot_h.
- D update on edge when dreg_en_h=1:
  - 00: D <= wmux_h.
  - 01: D <= {dshr_in_h, D[WIDTH-1:1]}.
  - 10: D <= {D[WIDTH-2:0], dshl_in_h}.
  - 11: hold.
- dreg_en_h=0: D holds.
- Q and D update independently in the same cycle. Shift sources use the pre-edge register value; there is no read-after-write within a cycle.
- Double-width shift across Q and D is done externally by tying qlsb_h to dshr_in_h, etc. No internal Q/D coupling.

Optional Feature:
- ALP_DQ_CHK_EN defined:
  - Adds output dqerr_h (1 bit).
  - Sticky flag set on any edge where qreg_en_h=1 and qmux_onehot_h has more than one bit set, excluding the bit2+bit1 pair.
  - Cleared only by reset_h.
  - Reset value 0.
  - The flag does not alter the Q update; priority still applies.
- ALP_DQ_CHK_EN undefined: no dqerr_h port, no extra state.

Test Plan:
- Reset: hold reset_h=1 with qreg_en_h=1, dreg_en_h=1, wmux_h=8'hFF for 2 cycles -> q_h=8'h00, d_h=8'h00; after release, one load edge -> q_h=8'hFF, d_h=8'hFF.
- Q loads: qreg_en_h=1, onehot 1000, wmux_h=8'hA5 -> q_h=8'hA5. Next edge onehot 0001, amux_h=8'h3C -> q_h=8'h3C. Next edge qreg_en_h=0, onehot 1000 -> q_h stays 8'h3C.
- Q shifts: Q=8'h81.
  - onehot 0100 with qshl_in_h=1 -> q_h=8'h03, qmsb_h=0.
  - Then onehot 0010 with qshr_in_h=1 -> q_h=8'h81, qlsb_h=1.
- Priority: Q=8'h81, qreg_en_h=1, onehot 0110, qshl_in_h=0 -> q_h=8'h02 (left wins). Onehot 1111, wmux_h=8'h55 -> q_h=8'h55; with ALP_DQ_CHK_EN, dqerr_h=1 next cycle and stays 1 until reset.
- D path: dreg_en_h=1, dshift_h=00, wmux_h=8'hF0 -> d_h=8'hF0.
  - 01 with dshr_in_h=0 -> 8'h78.
  - 10 with dshl_in_h=1 -> 8'hF1.
  - 11 -> holds 8'hF1.
  - dreg_en_h=0 with 00 -> holds.
- Concurrent and reset-during-shift: Q load 8'h12 and D load 8'h34 on the same edge -> both visible next cycle. Start a Q shift-left run, then assert reset_h mid-run together with a load -> Q=0, D=0.

Source files
------------

// File: rtl/alp_dq_reg.sv
// ALP slice Q/D storage stage: Q scratch register and D data latch, updated from decoder controls.
// Optional ALP_DQ_CHK_EN adds a sticky dqerr_h flag for illegal multi-hot Q source selects.
module alp_dq_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_h,
    input  logic [3:0]       qmux_onehot_h,
    input  logic             qreg_en_h,
    input  logic             dreg_en_h,
    input  logic [1:0]       dshift_h,
    input  logic [WIDTH-1:0] amux_h,
    input  logic [WIDTH-1:0] wmux_h,
    input  logic             qshl_in_h,
    input  logic             qshr_in_h,
    input  logic             dshl_in_h,
    input  logic             dshr_in_h,
    output logic [WIDTH-1:0] q_h,
    output logic [WIDTH-1:0] d_h,
    output logic             qmsb_h,
    output logic             qlsb_h,
    output logic             dmsb_h,
    output logic             dlsb_h
`ifdef ALP_DQ_CHK_EN
    ,
    output logic             dqerr_h
`endif
);

    localparam logic [1:0] D_LOAD = 2'b00;
    localparam logic [1:0] D_SHR  = 2'b01;
    localparam logic [1:0] D_SHL  = 2'b10;

    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] d_q, d_d;

    // Fixed priority W > shl > shr > A keeps the decoder's shl+shr overlap deterministic.
    function automatic logic [WIDTH-1:0] q_next(
        input logic [WIDTH-1:0] cur,
        input logic [3:0]       sel,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] w,
        input logic             shl_in,
        input logic             shr_in
    );
        logic [WIDTH-1:0] r;
        r = cur;
        if (sel[3])      r = w;
        else if (sel[2]) r = {cur[WIDTH-2:0], shl_in};
        else if (sel[1]) r = {shr_in, cur[WIDTH-1:1]};
        else if (sel[0]) r = a;
        return r;
    endfunction

    function automatic logic [WIDTH-1:0] d_next(
        input logic [WIDTH-1:0] cur,
        input logic [1:0]       op,
        input logic [WIDTH-1:0] w,
        input logic             shl_in,
        input logic             shr_in
    );
        logic [WIDTH-1:0] r;
        case (op)
            D_LOAD:  r = w;
            D_SHR:   r = {shr_in, cur[WIDTH-1:1]};
            D_SHL:   r = {cur[WIDTH-2:0], shl_in};
            default: r = cur;
        endcase
        return r;
    endfunction

    always_comb begin
        q_d = q_q;
        d_d = d_q;
        if (qreg_en_h)
            q_d = q_next(q_q, qmux_onehot_h, amux_h, wmux_h, qshl_in_h, qshr_in_h);
        if (dreg_en_h)
            d_d = d_next(d_q, dshift_h, wmux_h, dshl_in_h, dshr_in_h);
    end

    always_ff @(posedge clk) begin
        if (reset_h) begin
            q_q <= '0;
            d_q <= '0;
        end else begin
            q_q <= q_d;
            d_q <= d_d;
        end
    end

`ifdef ALP_DQ_CHK_EN
    logic dqerr_q, dqerr_d;
    logic multi_hot;

    // More than one select bit is illegal except the shl+shr pair the decoder may emit.
    always_comb begin
        multi_hot = ($countones(qmux_onehot_h) > 1) && (qmux_onehot_h != 4'b0110);
        dqerr_d   = dqerr_q | (qreg_en_h & multi_hot);
    end

    always_ff @(posedge clk) begin
        if (reset_h) dqerr_q <= 1'b0;
        else         dqerr_q <= dqerr_d;
    end

    assign dqerr_h = dqerr_q;
`endif

    assign q_h    = q_q;
    assign d_h    = d_q;
    assign qmsb_h = q_q[WIDTH-1];
    assign qlsb_h = q_q[0];
    assign dmsb_h = d_q[WIDTH-1];
    assign dlsb_h = d_q[0];

endmodule

// File: tb/tb_alp_dq_reg.sv
// Scoreboard bench for alp_dq_reg: directed vectors push expected register state, a monitor compares.
module tb_alp_dq_reg;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset_h = 1'b1;
    logic [3:0]   qmux_onehot_h = '0;
    logic         qreg_en_h = 1'b0;
    logic         dreg_en_h = 1'b0;
    logic [1:0]   dshift_h = 2'b11;
    logic [W-1:0] amux_h = '0;
    logic [W-1:0] wmux_h = '0;
    logic         qshl_in_h = 1'b0;
    logic         qshr_in_h = 1'b0;
    logic         dshl_in_h = 1'b0;
    logic         dshr_in_h = 1'b0;
    logic [W-1:0] q_h, d_h;
    logic         qmsb_h, qlsb_h, dmsb_h, dlsb_h;
`ifdef ALP_DQ_CHK_EN
    logic         dqerr_h;
`endif

    alp_dq_reg #(.WIDTH(W)) dut (
        .clk(clk), .reset_h(reset_h), .qmux_onehot_h(qmux_onehot_h),
        .qreg_en_h(qreg_en_h), .dreg_en_h(dreg_en_h), .dshift_h(dshift_h),
        .amux_h(amux_h), .wmux_h(wmux_h),
        .qshl_in_h(qshl_in_h), .qshr_in_h(qshr_in_h),
        .dshl_in_h(dshl_in_h), .dshr_in_h(dshr_in_h),
        .q_h(q_h), .d_h(d_h), .qmsb_h(qmsb_h), .qlsb_h(qlsb_h),
        .dmsb_h(dmsb_h), .dlsb_h(dlsb_h)
`ifdef ALP_DQ_CHK_EN
        , .dqerr_h(dqerr_h)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int           id;
        logic [W-1:0] q;
        logic [W-1:0] d;
        logic         err;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input int id, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s vec%0d: got %h expected %h", name, id, act, req);
        end
    endtask

    // Monitor: every edge produces new register state, compared 1 time unit later.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t e;
            logic [W-1:0] eq, ed;
            e  = exp_q.pop_front();
            eq = e.q;
            ed = e.d;
            chk("q_h",    e.id, q_h, eq);
            chk("d_h",    e.id, d_h, ed);
            chk("qmsb_h", e.id, {{(W-1){1'b0}}, qmsb_h}, {{(W-1){1'b0}}, eq[W-1]});
            chk("qlsb_h", e.id, {{(W-1){1'b0}}, qlsb_h}, {{(W-1){1'b0}}, eq[0]});
            chk("dmsb_h", e.id, {{(W-1){1'b0}}, dmsb_h}, {{(W-1){1'b0}}, ed[W-1]});
            chk("dlsb_h", e.id, {{(W-1){1'b0}}, dlsb_h}, {{(W-1){1'b0}}, ed[0]});
`ifdef ALP_DQ_CHK_EN
            chk("dqerr_h", e.id, {{(W-1){1'b0}}, dqerr_h}, {{(W-1){1'b0}}, e.err});
`endif
        end
    end

    int vec = 0;

    // Drive one cycle of inputs on the falling edge and queue the state expected after the next rising edge.
    task automatic cyc(input logic rst, input logic qen, input logic den,
                       input logic [3:0] oh, input logic [1:0] ds,
                       input logic [W-1:0] a, input logic [W-1:0] w,
                       input logic qshl, input logic qshr, input logic dshl, input logic dshr,
                       input logic [W-1:0] eq, input logic [W-1:0] ed, input logic eerr);
        exp_t e;
        @(negedge clk);
        reset_h = rst; qreg_en_h = qen; dreg_en_h = den;
        qmux_onehot_h = oh; dshift_h = ds; amux_h = a; wmux_h = w;
        qshl_in_h = qshl; qshr_in_h = qshr; dshl_in_h = dshl; dshr_in_h = dshr;
        vec++;
        e.id = vec; e.q = eq; e.d = ed; e.err = eerr;
        exp_q.push_back(e);
    endtask

    initial begin
        //  rst qen den  oh       ds     amux   wmux   qshl qshr dshl dshr  expQ   expD   err
        cyc(1, 1, 1, 4'b1000, 2'b00, 8'h00, 8'hFF, 0, 0, 0, 0, 8'h00, 8'h00, 0);
        cyc(1, 1, 1, 4'b1000, 2'b00, 8'h00, 8'hFF, 0, 0, 0, 0, 8'h00, 8'h00, 0);
        cyc(0, 1, 1, 4'b1000, 2'b00, 8'h00, 8'hFF, 0, 0, 0, 0, 8'hFF, 8'hFF, 0);
        cyc(0, 1, 0, 4'b1000, 2'b00, 8'h00, 8'hA5, 0, 0, 0, 0, 8'hA5, 8'hFF, 0);
        cyc(0, 1, 0, 4'b0001, 2'b00, 8'h3C, 8'hA5, 0, 0, 0, 0, 8'h3C, 8'hFF, 0);
        cyc(0, 0, 0, 4'b1000, 2'b00, 8'h00, 8'hA5, 0, 0, 0, 0, 8'h3C, 8'hFF, 0);
        cyc(0, 1, 0, 4'b1000, 2'b00, 8'h00, 8'h81, 0, 0, 0, 0, 8'h81, 8'hFF, 0);
        cyc(0, 1, 0, 4'b0100, 2'b00, 8'h00, 8'h00, 1, 0, 0, 0, 8'h03, 8'hFF, 0);
        cyc(0, 1, 0, 4'b0010, 2'b00, 8'h00, 8'h00, 0, 1, 0, 0, 8'h81, 8'hFF, 0);
        cyc(0, 1, 0, 4'b0110, 2'b00, 8'h00, 8'h00, 0, 1, 0, 0, 8'h02, 8'hFF, 0);
        cyc(0, 1, 0, 4'b1111, 2'b00, 8'hAA, 8'h55, 1, 1, 0, 0, 8'h55, 8'hFF, 1);
        cyc(0, 0, 1, 4'b0000, 2'b00, 8'h00, 8'hF0, 0, 0, 0, 0, 8'h55, 8'hF0, 1);
        cyc(0, 0, 1, 4'b0000, 2'b01, 8'h00, 8'h00, 0, 0, 1, 0, 8'h55, 8'h78, 1);
        cyc(0, 0, 1, 4'b0000, 2'b10, 8'h00, 8'h00, 0, 0, 1, 0, 8'h55, 8'hF1, 1);
        cyc(0, 0, 1, 4'b0000, 2'b11, 8'h00, 8'h00, 0, 0, 0, 1, 8'h55, 8'hF1, 1);
        cyc(0, 0, 0, 4'b0000, 2'b00, 8'h00, 8'h00, 0, 0, 0, 0, 8'h55, 8'hF1, 1);
        cyc(0, 1, 1, 4'b0000, 2'b00, 8'h00, 8'h00, 0, 0, 0, 0, 8'h55, 8'h00, 1);
        cyc(0, 1, 1, 4'b0001, 2'b00, 8'h12, 8'h34, 0, 0, 0, 0, 8'h12, 8'h34, 1);
        cyc(0, 1, 0, 4'b0100, 2'b00, 8'h00, 8'h00, 1, 0, 0, 0, 8'h25, 8'h34, 1);
        cyc(0, 1, 0, 4'b0100, 2'b00, 8'h00, 8'h00, 0, 0, 0, 0, 8'h4A, 8'h34, 1);
        cyc(1, 1, 1, 4'b1000, 2'b00, 8'h00, 8'hFF, 0, 0, 0, 0, 8'h00, 8'h00, 0);
        cyc(0, 1, 1, 4'b0100, 2'b01, 8'h00, 8'h00, 1, 0, 0, 1, 8'h01, 8'h80, 0);
        cyc(0, 1, 1, 4'b0010, 2'b10, 8'h00, 8'h00, 0, 1, 1, 0, 8'h80, 8'h01, 0);
        cyc(0, 1, 0, 4'b1001, 2'b11, 8'h0F, 8'hC3, 0, 0, 0, 0, 8'hC3, 8'h01, 1);
        @(negedge clk);
        qreg_en_h = 1'b0; dreg_en_h = 1'b0;
        begin
            int budget = 20;
            while (exp_q.size() > 0 && budget > 0) begin
                @(negedge clk);
                budget--;
            end
            checks++;
            if (exp_q.size() != 0) begin
                errors++;
                $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
            end
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
